// File: rtl/hud_pkg.sv
// Shared HUD definitions: bar geometry, sprite table type, drain FSM states.
package hud_pkg;

  localparam int unsigned BAR_W    = 144;
  localparam int unsigned BAR_H    = 12;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned HEALTH_W = 8;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned LX_W     = 8;
  localparam int unsigned LY_W     = 4;

  typedef logic [0:BAR_H-1][0:BAR_W-1][0:IDX_W-1] bar_bitmap_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLASH = 2'd2
  } bar_state_t;

  // Limit a game-logic target to the displayable range.
  function automatic logic [HEALTH_W-1:0] clamp_health(
    input logic [HEALTH_W-1:0] raw,
    input logic [HEALTH_W-1:0] max_h
  );
    return (raw > max_h) ? max_h : raw;
  endfunction

  // One drain step, computed in 9 bits so it never wraps and never passes the floor.
  function automatic logic [HEALTH_W-1:0] step_down(
    input logic [HEALTH_W-1:0] shown,
    input logic [HEALTH_W-1:0] step,
    input logic [HEALTH_W-1:0] floor_h
  );
    logic [HEALTH_W:0] diff;
    diff = {1'b0, shown} - {1'b0, step};
    if (diff[HEALTH_W] || (diff[HEALTH_W-1:0] < floor_h)) begin
      return floor_h;
    end
    return diff[HEALTH_W-1:0];
  endfunction

endpackage

// File: rtl/health_drain_fsm.sv
// Frame-rate health animation: drains toward the target, flashes, heals instantly.
module health_drain_fsm
  import hud_pkg::*;
#(
  parameter int unsigned HEALTH_MAX   = 144,
  parameter int unsigned DRAIN_STEP   = 2,
  parameter int unsigned FLASH_FRAMES = 16
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_start,
  input  logic [HEALTH_W-1:0] health_target,
  output logic [HEALTH_W-1:0] health_shown,
  output logic                busy,
  output logic                flash_odd
);

  localparam int unsigned CNT_W = (FLASH_FRAMES > 2) ? $clog2(FLASH_FRAMES) : 1;

  bar_state_t          state;
  bar_state_t          state_nxt;
  logic [HEALTH_W-1:0] shown_nxt;
  logic [CNT_W-1:0]    flash_cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                busy_nxt;
  logic                flash_odd_nxt;
  logic [HEALTH_W-1:0] tgt_c;
  logic [HEALTH_W-1:0] drained_c;

  assign tgt_c     = clamp_health(health_target, HEALTH_W'(HEALTH_MAX));
  assign drained_c = step_down(health_shown, HEALTH_W'(DRAIN_STEP), tgt_c);

  // State register: state, displayed health, flash counter and registered status outputs.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state        <= IDLE;
      health_shown <= HEALTH_W'(HEALTH_MAX);
      flash_cnt    <= '0;
      busy         <= 1'b0;
      flash_odd    <= 1'b0;
    end else begin
      state        <= state_nxt;
      health_shown <= shown_nxt;
      flash_cnt    <= cnt_nxt;
      busy         <= busy_nxt;
      flash_odd    <= flash_odd_nxt;
    end
  end

  // Next-state logic, evaluated only on the frame pulse so a frame never tears.
  always_comb begin
    state_nxt = state;
    shown_nxt = health_shown;
    cnt_nxt   = flash_cnt;
    if (frame_start) begin
      case (state)
        IDLE: begin
          if (tgt_c < health_shown) begin
            shown_nxt = drained_c;
            state_nxt = DRAIN;
          end else if (tgt_c > health_shown) begin
            shown_nxt = tgt_c;
          end
        end
        DRAIN: begin
          if (tgt_c > health_shown) begin
            shown_nxt = tgt_c;
            state_nxt = IDLE;
          end else begin
            shown_nxt = drained_c;
            if (drained_c == tgt_c) begin
              state_nxt = FLASH;
              cnt_nxt   = '0;
            end
          end
        end
        FLASH: begin
          if (tgt_c < health_shown) begin
            state_nxt = DRAIN;
            cnt_nxt   = '0;
          end else if (tgt_c > health_shown) begin
            shown_nxt = tgt_c;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (flash_cnt == CNT_W'(FLASH_FRAMES - 1)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = flash_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode from the next state, registered alongside it.
  always_comb begin
    busy_nxt      = (state_nxt != IDLE);
    flash_odd_nxt = (state_nxt == FLASH) && cnt_nxt[0];
  end

endmodule

// File: rtl/health_bar_renderer.sv
// Per-pixel health bar: bitmap label lookup with an animated fill, two-stage pipeline.
module health_bar_renderer
  import hud_pkg::*;
#(
  parameter int unsigned BAR_X        = 16,
  parameter int unsigned BAR_Y        = 8,
  parameter int unsigned HEALTH_MAX   = 144,
  parameter int unsigned MIRROR       = 0,
  parameter int unsigned DRAIN_STEP   = 2,
  parameter int unsigned FLASH_FRAMES = 16,
  parameter int unsigned FILL_IDX     = 12,
  parameter int unsigned EMPTY_IDX    = 1,
  parameter int unsigned FLASH_IDX    = 63
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_start,
  input  logic                pixel_en,
  input  logic [COORD_W-1:0]  DrawX,
  input  logic [COORD_W-1:0]  DrawY,
  input  bar_bitmap_t         bar_bitmap,
  input  logic [HEALTH_W-1:0] health_target,
  output logic [IDX_W-1:0]    pix_idx,
  output logic                pix_hit,
  output logic                pix_valid,
  output logic [HEALTH_W-1:0] health_shown,
  output logic                busy
);

  logic [COORD_W-1:0] dx_c;
  logic [COORD_W-1:0] dy_c;
  logic               inbar_c;
  logic               s1_en;
  logic               s1_inbar;
  logic [LX_W-1:0]    s1_lx;
  logic [LY_W-1:0]    s1_ly;
  logic [IDX_W-1:0]   b_c;
  logic               filled_c;
  logic [IDX_W-1:0]   idx_c;
  logic               flash_odd;

  health_drain_fsm #(
    .HEALTH_MAX  (HEALTH_MAX),
    .DRAIN_STEP  (DRAIN_STEP),
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_fsm (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_start  (frame_start),
    .health_target(health_target),
    .health_shown (health_shown),
    .busy         (busy),
    .flash_odd    (flash_odd)
  );

  // Bar-local coordinates; wrap-around makes left/above pixels fail the compare.
  always_comb begin
    dx_c    = DrawX - COORD_W'(BAR_X);
    dy_c    = DrawY - COORD_W'(BAR_Y);
    inbar_c = (dx_c < COORD_W'(BAR_W)) && (dy_c < COORD_W'(BAR_H));
  end

  // Stage 1: register hit test, local coordinates and pixel enable.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_en    <= 1'b0;
      s1_inbar <= 1'b0;
      s1_lx    <= '0;
      s1_ly    <= '0;
    end else begin
      s1_en    <= pixel_en;
      s1_inbar <= inbar_c;
      s1_lx    <= dx_c[LX_W-1:0];
      s1_ly    <= dy_c[LY_W-1:0];
    end
  end

  // Stage 2 colour select: label beats fill, fill beats empty interior.
  always_comb begin
    b_c = bar_bitmap[s1_ly][s1_lx];
    if (MIRROR != 0) begin
      filled_c = ({1'b0, s1_lx} >= ((HEALTH_W + 1)'(HEALTH_MAX) - {1'b0, health_shown}));
    end else begin
      filled_c = ({1'b0, s1_lx} < {1'b0, health_shown});
    end
    idx_c = '0;
    if (s1_inbar) begin
      if (b_c != '0) begin
        idx_c = b_c;
      end else if (filled_c) begin
        idx_c = flash_odd ? IDX_W'(FLASH_IDX) : IDX_W'(FILL_IDX);
      end else begin
        idx_c = IDX_W'(EMPTY_IDX);
      end
    end
  end

  // Stage 2 register: colour and hit update only for enabled pixels.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pix_idx   <= '0;
      pix_hit   <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= s1_en;
      if (s1_en) begin
        pix_idx <= idx_c;
        pix_hit <= s1_inbar;
      end
    end
  end

endmodule
